// File: rtl/ip_mem_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ip_mem_bus_arbiter_pkg
// Shared definitions for the two-requester memory bus arbiter:
//   - state_t          : FSM state encoding (IDLE / READ / WRITE / GAP)
//   - TIMEOUT_DEFAULT  : default number of read-wait cycles before abort
//   - TIMEOUT_RDATA    : read data returned to a requester on a timed-out read
// ---------------------------------------------------------------------------
package ip_mem_bus_arbiter_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 15;

  localparam logic [7:0] TIMEOUT_RDATA = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

endpackage

// File: rtl/ip_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// ip_mem_bus_arbiter
// Arbitrates two requesters (m0, m1) onto one shared memory bus. Each
// transaction is a single read or write strobe, followed by a one-cycle GAP
// so that slaves, which detect rising strobe edges, always see a low cycle
// between transactions. Ties are resolved round-robin; reads that get no
// bus_read_ready within TIMEOUT strobe cycles return 8'hFF.
//
// Parameters
//   TIMEOUT           read-wait cycles before abort (2..255)
// Ports
//   clk               system clock
//   n_reset           synchronous, active-low reset
//   mN_address[15:0]  requester N address            (N = 0, 1)
//   mN_wdata[7:0]     requester N write data
//   mN_read           requester N read request (level, held until ack)
//   mN_write          requester N write request (level, held until ack)
//   mN_ack            requester N one-cycle completion pulse
//   mN_rdata[7:0]     requester N read result, valid while mN_ack = 1
//   bus_address       shared address, held from grant to next grant
//   bus_write_data    shared write data, held from grant to next grant
//   bus_memory_read   shared read strobe
//   bus_memory_write  shared write strobe
//   bus_read_ready    slave read-data valid pulse
//   bus_read_data     slave read data (OR of all slaves)
// All outputs are registered.
// ---------------------------------------------------------------------------
module ip_mem_bus_arbiter
  import ip_mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] m0_address,
  input  logic [7:0]  m0_wdata,
  input  logic        m0_read,
  input  logic        m0_write,
  output logic        m0_ack,
  output logic [7:0]  m0_rdata,
  input  logic [15:0] m1_address,
  input  logic [7:0]  m1_wdata,
  input  logic        m1_read,
  input  logic        m1_write,
  output logic        m1_ack,
  output logic [7:0]  m1_rdata,
  output logic [15:0] bus_address,
  output logic [7:0]  bus_write_data,
  output logic        bus_memory_read,
  output logic        bus_memory_write,
  input  logic        bus_read_ready,
  input  logic [7:0]  bus_read_data
);

  // Counter value of the last strobe cycle a read is allowed to wait.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_next;
  logic [7:0]  wait_cnt;
  logic [7:0]  wait_cnt_next;
  logic        grant;        // requester owning the current transaction
  logic        grant_next;
  logic        last_grant;   // requester granted most recently (1 => m0 wins next tie)
  logic        last_grant_next;

  logic [15:0] address_next;
  logic [7:0]  write_data_next;
  logic        memory_read_next;
  logic        memory_write_next;
  logic        m0_ack_next;
  logic        m1_ack_next;
  logic [7:0]  m0_rdata_next;
  logic [7:0]  m1_rdata_next;

  logic        req0;
  logic        req1;
  logic        sel;          // requester picked if a grant happens this cycle
  logic        sel_read;     // picked request is a read (read wins over write)
  logic        read_expired;

  assign req0         = m0_read | m0_write;
  assign req1         = m1_read | m1_write;
  assign sel          = (req0 & req1) ? ~last_grant : req1;
  assign sel_read     = sel ? m1_read : m0_read;
  assign read_expired = (wait_cnt == WAIT_LAST);

  // State and registered-output flops with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state            <= ST_IDLE;
      wait_cnt         <= 8'd0;
      grant            <= 1'b0;
      last_grant       <= 1'b1;
      bus_address      <= 16'h0000;
      bus_write_data   <= 8'h00;
      bus_memory_read  <= 1'b0;
      bus_memory_write <= 1'b0;
      m0_ack           <= 1'b0;
      m1_ack           <= 1'b0;
      m0_rdata         <= 8'h00;
      m1_rdata         <= 8'h00;
    end else begin
      state            <= state_next;
      wait_cnt         <= wait_cnt_next;
      grant            <= grant_next;
      last_grant       <= last_grant_next;
      bus_address      <= address_next;
      bus_write_data   <= write_data_next;
      bus_memory_read  <= memory_read_next;
      bus_memory_write <= memory_write_next;
      m0_ack           <= m0_ack_next;
      m1_ack           <= m1_ack_next;
      m0_rdata         <= m0_rdata_next;
      m1_rdata         <= m1_rdata_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (req0 | req1) begin
          state_next = sel_read ? ST_READ : ST_WRITE;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_READ: begin
        if (bus_read_ready | read_expired) begin
          state_next = ST_GAP;
        end else begin
          state_next = ST_READ;
        end
      end
      ST_WRITE: state_next = ST_GAP;
      ST_GAP:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath state.
  // Strobes and acks default low, so GAP drops both and clears the ack.
  always_comb begin
    address_next      = bus_address;
    write_data_next   = bus_write_data;
    memory_read_next  = 1'b0;
    memory_write_next = 1'b0;
    m0_ack_next       = 1'b0;
    m1_ack_next       = 1'b0;
    m0_rdata_next     = m0_rdata;
    m1_rdata_next     = m1_rdata;
    wait_cnt_next     = wait_cnt;
    grant_next        = grant;
    last_grant_next   = last_grant;
    case (state)
      ST_IDLE: begin
        if (req0 | req1) begin
          grant_next        = sel;
          last_grant_next   = sel;
          address_next      = sel ? m1_address : m0_address;
          write_data_next   = sel ? m1_wdata : m0_wdata;
          memory_read_next  = sel_read;
          memory_write_next = ~sel_read;
          wait_cnt_next     = 8'd0;
        end else begin
          wait_cnt_next     = wait_cnt;
        end
      end
      ST_READ: begin
        if (bus_read_ready) begin
          if (grant) begin
            m1_ack_next   = 1'b1;
            m1_rdata_next = bus_read_data;
          end else begin
            m0_ack_next   = 1'b1;
            m0_rdata_next = bus_read_data;
          end
        end else if (read_expired) begin
          if (grant) begin
            m1_ack_next   = 1'b1;
            m1_rdata_next = TIMEOUT_RDATA;
          end else begin
            m0_ack_next   = 1'b1;
            m0_rdata_next = TIMEOUT_RDATA;
          end
        end else begin
          memory_read_next = 1'b1;
          wait_cnt_next    = wait_cnt + 8'd1;
        end
      end
      ST_WRITE: begin
        if (grant) begin
          m1_ack_next = 1'b1;
        end else begin
          m0_ack_next = 1'b1;
        end
      end
      ST_GAP: begin
        wait_cnt_next = wait_cnt;
      end
      default: begin
        wait_cnt_next = 8'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_ip_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ip_mem_bus_arbiter
// Directed scenarios with hand-computed expectations, then randomized
// requester/slave traffic. A transaction-level reference model predicts every
// output after each clock edge and a monitor compares all outputs each cycle.
// ---------------------------------------------------------------------------
module tb_ip_mem_bus_arbiter;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        rq_rd   [2];
  logic        rq_wr   [2];
  logic [15:0] rq_addr [2];
  logic [7:0]  rq_wd   [2];
  logic        m0_ack, m1_ack;
  logic [7:0]  m0_rdata, m1_rdata;
  logic [15:0] bus_address;
  logic [7:0]  bus_write_data;
  logic        bus_memory_read, bus_memory_write;
  logic        bus_read_ready;
  logic [7:0]  bus_read_data;
  logic        acks [2];

  assign acks[0] = m0_ack;
  assign acks[1] = m1_ack;

  always #5 clk = ~clk;

  ip_mem_bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk              (clk),
    .n_reset          (n_reset),
    .m0_address       (rq_addr[0]),
    .m0_wdata         (rq_wd[0]),
    .m0_read          (rq_rd[0]),
    .m0_write         (rq_wr[0]),
    .m0_ack           (m0_ack),
    .m0_rdata         (m0_rdata),
    .m1_address       (rq_addr[1]),
    .m1_wdata         (rq_wd[1]),
    .m1_read          (rq_rd[1]),
    .m1_write         (rq_wr[1]),
    .m1_ack           (m1_ack),
    .m1_rdata         (m1_rdata),
    .bus_address      (bus_address),
    .bus_write_data   (bus_write_data),
    .bus_memory_read  (bus_memory_read),
    .bus_memory_write (bus_memory_write),
    .bus_read_ready   (bus_read_ready),
    .bus_read_data    (bus_read_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit          mv = 1'b0;
  logic [15:0] e_addr;
  logic [7:0]  e_wdata;
  logic        e_rd, e_wr;
  logic        e_ack   [2];
  logic [7:0]  e_rdata [2];
  bit          m_last, m_busy, m_gap, m_isrd, m_owner;
  int          m_n;

  task automatic model_step();
    logic r0, r1;
    bit   sel;
    r0 = rq_rd[0] | rq_wr[0];
    r1 = rq_rd[1] | rq_wr[1];
    if (!n_reset) begin
      e_addr = 16'h0; e_wdata = 8'h0; e_rd = 1'b0; e_wr = 1'b0;
      e_ack[0] = 1'b0; e_ack[1] = 1'b0; e_rdata[0] = 8'h0; e_rdata[1] = 8'h0;
      m_last = 1'b1; m_busy = 1'b0; m_gap = 1'b0; m_n = 0;
    end else if (m_gap) begin
      m_gap = 1'b0; e_ack[0] = 1'b0; e_ack[1] = 1'b0;
    end else if (m_busy) begin
      if (!m_isrd) begin
        e_wr = 1'b0; e_ack[m_owner] = 1'b1; m_busy = 1'b0; m_gap = 1'b1;
      end else begin
        m_n++;
        if (bus_read_ready) begin
          e_rdata[m_owner] = bus_read_data;
          e_rd = 1'b0; e_ack[m_owner] = 1'b1; m_busy = 1'b0; m_gap = 1'b1;
        end else if (m_n == TO) begin
          e_rdata[m_owner] = 8'hFF;
          e_rd = 1'b0; e_ack[m_owner] = 1'b1; m_busy = 1'b0; m_gap = 1'b1;
        end
      end
    end else if (r0 || r1) begin
      if (r0 && r1) sel = !m_last;
      else          sel = r1;
      m_owner = sel;
      m_last  = sel;
      m_isrd  = rq_rd[sel];
      e_addr  = rq_addr[sel];
      e_wdata = rq_wd[sel];
      e_rd    = m_isrd;
      e_wr    = !m_isrd;
      m_busy  = 1'b1;
      m_n     = 0;
    end
  endtask

  // Monitor: advance the model at each edge, compare all outputs just after.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      mv = 1'b1;
      #1;
      check("bus_address", bus_address, e_addr);
      check("bus_write_data", bus_write_data, e_wdata);
      check("bus_memory_read", bus_memory_read, e_rd);
      check("bus_memory_write", bus_memory_write, e_wr);
      check("m0_ack", m0_ack, e_ack[0]);
      check("m1_ack", m1_ack, e_ack[1]);
      check("m0_rdata", m0_rdata, e_rdata[0]);
      check("m1_rdata", m1_rdata, e_rdata[1]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drop_all();
    for (int i = 0; i < 2; i++) begin
      rq_rd[i] = 1'b0; rq_wr[i] = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit act [2];
    int cnt;
    bit got;
    int k;

    n_reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rq_rd[i] = 1'b0; rq_wr[i] = 1'b0; rq_addr[i] = 16'h0; rq_wd[i] = 8'h0;
      act[i] = 1'b0;
    end
    bus_read_ready = 1'b0;
    bus_read_data  = 8'h00;
    cyc(2);
    check("rst_addr", bus_address, 16'h0000);
    check("rst_wdata", bus_write_data, 8'h00);
    check("rst_rd", bus_memory_read, 1'b0);
    check("rst_wr", bus_memory_write, 1'b0);
    check("rst_ack0", m0_ack, 1'b0);
    check("rst_rdata1", m1_rdata, 8'h00);
    n_reset = 1'b1;
    cyc(1);

    // m0 write 9000/5A
    rq_wr[0] = 1'b1; rq_addr[0] = 16'h9000; rq_wd[0] = 8'h5A;
    cyc(1);
    check("w_strobe", bus_memory_write, 1'b1);
    check("w_addr", bus_address, 16'h9000);
    check("w_data", bus_write_data, 8'h5A);
    check("w_ack_early", m0_ack, 1'b0);
    cyc(1);
    check("w_strobe_off", bus_memory_write, 1'b0);
    check("w_ack", m0_ack, 1'b1);
    rq_wr[0] = 1'b0;
    cyc(1);
    check("w_ack_clr", m0_ack, 1'b0);

    // m1 read 9000, slave ready one cycle after strobe with C3
    rq_rd[1] = 1'b1; rq_addr[1] = 16'h9000;
    cyc(1);
    check("r_strobe", bus_memory_read, 1'b1);
    check("r_addr", bus_address, 16'h9000);
    cyc(1);
    check("r_strobe_wait", bus_memory_read, 1'b1);
    bus_read_ready = 1'b1; bus_read_data = 8'hC3;
    cyc(1);
    check("r_ack", m1_ack, 1'b1);
    check("r_rdata", m1_rdata, 8'hC3);
    check("r_gap_strobe", bus_memory_read, 1'b0);
    bus_read_ready = 1'b0; bus_read_data = 8'h00; rq_rd[1] = 1'b0;
    cyc(1);
    check("r_ack_clr", m1_ack, 1'b0);
    check("r_rdata_hold", m1_rdata, 8'hC3);

    // Round-robin after reset: m0 first, then m1; after solo m0, tie -> m1
    n_reset = 1'b0;
    cyc(1);
    n_reset = 1'b1;
    rq_wr[0] = 1'b1; rq_addr[0] = 16'hA000; rq_wd[0] = 8'h11;
    rq_wr[1] = 1'b1; rq_addr[1] = 16'hB000; rq_wd[1] = 8'h22;
    cyc(1);
    check("rr1_addr", bus_address, 16'hA000);
    cyc(1);
    check("rr1_ack0", m0_ack, 1'b1);
    rq_wr[0] = 1'b0;
    cyc(2);
    check("rr2_addr", bus_address, 16'hB000);
    check("rr2_strobe", bus_memory_write, 1'b1);
    cyc(1);
    check("rr2_ack1", m1_ack, 1'b1);
    rq_wr[1] = 1'b0;
    cyc(1);
    rq_wr[0] = 1'b1; rq_addr[0] = 16'hC000;
    cyc(1);
    check("solo_addr", bus_address, 16'hC000);
    cyc(1);
    rq_wr[0] = 1'b0;
    cyc(1);
    rq_wr[0] = 1'b1; rq_addr[0] = 16'hD000;
    rq_wr[1] = 1'b1; rq_addr[1] = 16'hE000;
    cyc(1);
    check("rr3_addr_m1_first", bus_address, 16'hE000);
    cyc(1);
    check("rr3_ack1", m1_ack, 1'b1);
    rq_wr[1] = 1'b0;
    cyc(2);
    check("rr4_addr", bus_address, 16'hD000);
    cyc(1);
    check("rr4_ack0", m0_ack, 1'b1);
    rq_wr[0] = 1'b0;
    cyc(1);

    // Unmapped read, no ready: TIMEOUT strobe cycles then FF
    rq_rd[0] = 1'b1; rq_addr[0] = 16'h1234;
    cnt = 0; got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      cyc(1);
      if (m0_ack) got = 1'b1;
      else if (bus_memory_read) cnt++;
    end
    check("to_ack_seen", got, 1'b1);
    check("to_strobe_cycles", cnt, TO);
    check("to_rdata", m0_rdata, 8'hFF);
    rq_rd[0] = 1'b0;
    cyc(1);

    // Reset during READ aborts; fresh read afterwards completes
    rq_rd[0] = 1'b1; rq_addr[0] = 16'h4000;
    cyc(1);
    check("rst_mid_strobe", bus_memory_read, 1'b1);
    n_reset = 1'b0; rq_rd[0] = 1'b0;
    cyc(1);
    check("rst_mid_rd", bus_memory_read, 1'b0);
    check("rst_mid_addr", bus_address, 16'h0000);
    check("rst_mid_rdata0", m0_rdata, 8'h00);
    check("rst_mid_ack0", m0_ack, 1'b0);
    n_reset = 1'b1;
    cyc(1);
    check("rst_mid_noack", m0_ack, 1'b0);
    rq_rd[0] = 1'b1; rq_addr[0] = 16'h4000;
    cyc(1);
    check("fresh_strobe", bus_memory_read, 1'b1);
    bus_read_ready = 1'b1; bus_read_data = 8'h3C;
    cyc(1);
    check("fresh_ack", m0_ack, 1'b1);
    check("fresh_rdata", m0_rdata, 8'h3C);
    bus_read_ready = 1'b0; bus_read_data = 8'h00; rq_rd[0] = 1'b0;
    cyc(1);

    // Back-to-back m0 writes
    rq_wr[0] = 1'b1; rq_addr[0] = 16'h7000; rq_wd[0] = 8'h01;
    cyc(1);
    check("b2b_w1", bus_memory_write, 1'b1);
    cyc(1);
    check("b2b_ack1", m0_ack, 1'b1);
    check("b2b_low1", bus_memory_write, 1'b0);
    rq_wr[0] = 1'b0;
    cyc(1);
    check("b2b_low2", bus_memory_write, 1'b0);
    rq_wr[0] = 1'b1; rq_addr[0] = 16'h7001; rq_wd[0] = 8'h02;
    cyc(1);
    check("b2b_w2", bus_memory_write, 1'b1);
    check("b2b_w2_data", bus_write_data, 8'h02);
    cyc(1);
    check("b2b_ack2", m0_ack, 1'b1);
    rq_wr[0] = 1'b0;
    cyc(1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      cyc(1);
      if ($urandom_range(0, 399) == 0) begin
        n_reset = 1'b0;
        drop_all();
        act[0] = 1'b0; act[1] = 1'b0;
      end else begin
        n_reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
          if (act[i]) begin
            if (acks[i]) begin
              act[i] = 1'b0; rq_rd[i] = 1'b0; rq_wr[i] = 1'b0;
            end
          end else if ($urandom_range(0, 2) == 0) begin
            k = $urandom_range(0, 2);
            rq_rd[i]   = (k != 1);
            rq_wr[i]   = (k != 0);
            rq_addr[i] = 16'($urandom);
            rq_wd[i]   = 8'($urandom);
            act[i]     = 1'b1;
          end
        end
      end
      if (bus_memory_read && $urandom_range(0, 7) == 0) begin
        bus_read_ready = 1'b1; bus_read_data = 8'($urandom);
      end else if (!bus_memory_read && $urandom_range(0, 15) == 0) begin
        bus_read_ready = 1'b1; bus_read_data = 8'($urandom);
      end else begin
        bus_read_ready = 1'b0; bus_read_data = 8'h00;
      end
    end

    n_reset = 1'b1;
    drop_all();
    bus_read_ready = 1'b0; bus_read_data = 8'h00;
    cyc(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
